// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//
// Purpose:
//   Loads one configuration-chain segment from a stream of parallel bitstream
//   words. Words arrive over a valid/ready handshake, are serialised MSB first
//   onto ccff_head, and ccff_shift_en tells the integration clock gate on
//   which prog_clk edges the chain may shift. Exactly CHAIN_LEN shifts are
//   issued per pass, then done pulses for one cycle.
//
// Optional feature (macro CCFF_LOADER_READBACK_EN):
//   After the load pass a second, identical pass is streamed in (VERIFY).
//   Each shift of that pass compares the bit leaving the chain (ccff_tail)
//   with the bit entering it; any difference sets the sticky err flag.
//   Without the macro there is no VERIFY pass, ccff_tail is ignored and
//   err is tied to 0.
//
// Ports:
//   prog_clk       in   programming clock (loader logic itself is ungated)
//   prog_reset_n   in   synchronous active-low reset
//   start          in   one-cycle load request, honoured only in IDLE
//   bs_valid       in   bitstream word available on bs_data
//   bs_data        in   bitstream word, bit WORD_W-1 shifted first
//   bs_ready       out  loader accepts a word this cycle
//   ccff_head      out  registered serial bit into the chain
//   ccff_shift_en  out  registered chain clock enable
//   ccff_tail      in   chain output (readback only)
//   busy           out  high from the cycle after accepted start until done
//   done           out  one-cycle completion pulse
//   err            out  sticky readback mismatch
//   o_dbg_state    out  current FSM state (IDLE=0, LOAD=1, VERIFY=2, DONE=3)
//
// Handshake: a word is transferred on every rising prog_clk edge where
//   bs_valid and bs_ready are both 1; bs_ready never depends on bs_valid,
//   and the host must hold bs_data stable while bs_valid is 1.
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 30
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              bs_valid,
   input  logic [WORD_W-1:0] bs_data,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        o_dbg_state
);

   localparam int BW      = $clog2(CHAIN_LEN + 1);
   localparam int SW      = $clog2(WORD_W + 1);
   localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int WCW     = $clog2(N_WORDS + 1);

   localparam logic [BW-1:0]  LP_LEN     = BW'(CHAIN_LEN);
   localparam logic [BW-1:0]  LP_BIT_ONE = BW'(1);
   localparam logic [SW-1:0]  LP_WW      = SW'(WORD_W);
   localparam logic [SW-1:0]  LP_SH_ONE  = SW'(1);
   localparam logic [WCW-1:0] LP_NW      = WCW'(N_WORDS);
   localparam logic [WCW-1:0] LP_W_ONE   = WCW'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_VERIFY = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [BW-1:0]       r_bitcnt;
   logic [WCW-1:0]      r_wcnt;
   logic [WORD_W-1:0]   r_sh;
   logic [SW-1:0]       r_sh_cnt;
   logic [WORD_W-1:0]   r_hold;
   logic                r_hold_valid;
   logic                r_head;
   logic                r_shift_en;

   logic                w_active;
   logic                w_bs_ready;
   logic                w_accept;
   logic                w_pass_end;
   logic                w_fire;
   logic [WORD_W-1:0]   w_cur_data;
   logic [SW-1:0]       w_cur_cnt;
   logic                w_take_hold;
   logic                w_take_in;
   logic                w_start_ok;

   assign w_active   = (r_state == S_LOAD) || (r_state == S_VERIFY);
   // Words beyond one pass are left with the host.
   assign w_bs_ready = w_active && !r_hold_valid && (r_wcnt < LP_NW);
   assign w_accept   = w_bs_ready && bs_valid;
   assign w_pass_end = w_active && (r_bitcnt == LP_LEN);
   assign w_start_ok = (r_state == S_IDLE) && start;

   // Word supplying this cycle's bit. When the shift register is empty the
   // holding register, or failing that the word being accepted right now, is
   // used directly; this keeps first-word latency at one edge and avoids a
   // bubble when the shift register drains.
   always_comb begin
      w_cur_data  = r_sh;
      w_cur_cnt   = r_sh_cnt;
      w_take_hold = 1'b0;
      w_take_in   = 1'b0;
      if (r_sh_cnt == '0) begin
         if (r_hold_valid) begin
            w_cur_data  = r_hold;
            w_cur_cnt   = LP_WW;
            w_take_hold = 1'b1;
         end else if (w_accept) begin
            w_cur_data  = bs_data;
            w_cur_cnt   = LP_WW;
            w_take_in   = 1'b1;
         end
      end
   end

   // Bits of the final word past CHAIN_LEN are never fired and get dropped.
   assign w_fire = w_active && (w_cur_cnt != '0) && (r_bitcnt < LP_LEN);

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
`ifdef CCFF_LOADER_READBACK_EN
            if (w_pass_end) w_state_nxt = S_VERIFY;
`else
            if (w_pass_end) w_state_nxt = S_DONE;
`endif
         end
         S_VERIFY: begin
            if (w_pass_end) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         r_bitcnt     <= '0;
         r_wcnt       <= '0;
         r_sh         <= '0;
         r_sh_cnt     <= '0;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_head       <= 1'b0;
         r_shift_en   <= 1'b0;
      end else begin
         r_shift_en <= w_fire;

         if (w_fire) begin
            r_head   <= w_cur_data[WORD_W-1];
            r_bitcnt <= r_bitcnt + LP_BIT_ONE;
            r_sh     <= w_cur_data << 1;
            r_sh_cnt <= w_cur_cnt - LP_SH_ONE;
         end else begin
            r_sh     <= w_cur_data;
            r_sh_cnt <= w_cur_cnt;
         end

         if (w_take_hold) begin
            r_hold_valid <= 1'b0;
         end
         if (w_accept && !w_take_in) begin
            r_hold       <= bs_data;
            r_hold_valid <= 1'b1;
         end

         if (w_accept) begin
            r_wcnt <= r_wcnt + LP_W_ONE;
         end

         // Fresh pass: counters and buffers restart. Leftover LSBs of the
         // final word are discarded here.
         if ((r_state == S_IDLE) || w_pass_end) begin
            r_bitcnt     <= '0;
            r_wcnt       <= '0;
            r_sh_cnt     <= '0;
            r_hold_valid <= 1'b0;
         end
      end
   end

`ifdef CCFF_LOADER_READBACK_EN
   logic r_err;

   // During VERIFY the chain tail presents the bit loaded CHAIN_LEN shifts
   // earlier, which must equal the bit now entering at the head.
   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         r_err <= 1'b0;
      end else if (w_start_ok) begin
         r_err <= 1'b0;
      end else if ((r_state == S_VERIFY) && r_shift_en && (ccff_tail != r_head)) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   logic w_unused_tail;
   logic w_unused_start_ok;

   assign w_unused_tail     = ccff_tail;
   assign w_unused_start_ok = w_start_ok;
   assign err               = 1'b0;
`endif

   // ------------------------------------------------------------- outputs
   assign bs_ready      = w_bs_ready;
   assign ccff_head     = r_head;
   // Gated by reset so the chain never shifts on the edge that resets us.
   assign ccff_shift_en = r_shift_en & prog_reset_n;
   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_DONE);
   assign o_dbg_state   = r_state;

endmodule
